// File: rtl/weight_az_pkg.sv
// Shared constants, FSM state type and the saturating round helper for the
// bandwidth-expansion (Weight_Az) block.
package weight_az_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned M      = 10;

   localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;

   localparam logic [ADDR_W-1:0] A_BASE     = 12'd768;
   localparam logic [ADDR_W-1:0] AP_BASE    = 12'd528;
   localparam logic [ADDR_W-1:0] GAMMA_ADDR = 12'd448;

   typedef enum logic [2:0] {
      IDLE,
      RD_GAMMA,
      WAIT_GAMMA,
      RD_A,
      WAIT_A,
      CALC,
      WR_AP,
      DONE
   } state_t;

   // Saturating L + 0x8000, returning the high half
   function automatic logic [15:0] round_sat(input logic signed [31:0] l);
      logic signed [32:0] s;
      s = 33'(l) + 33'sh0_0000_8000;
      if (s > 33'(MAX_32))
         return 16'h7FFF;
      else if (s < 33'(MIN_32))
         return 16'h8000;
      else
         return 16'(s >>> 16);
   endfunction

endpackage

// File: rtl/weight_az_mult_round.sv
// round(L_mult(x, y)): Q15 x Q15 product doubled with the single overflow
// case saturated, then rounded back to 16 bits.
module weight_az_mult_round
   import weight_az_pkg::*;
(
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic [15:0] z
);

   logic signed [31:0] prod;
   logic signed [31:0] lm;

   always_comb begin
      prod = 32'(signed'(x)) * 32'(signed'(y));
      // -1 * -1 is the only product whose doubling overflows
      lm   = (x == 16'h8000 && y == 16'h8000) ? MAX_32 : (prod <<< 1);
      z    = round_sat(lm);
   end

endmodule

// File: rtl/weight_az_top.sv
// Weight_Az: ap[i] = a[i] * gamma^i computed from a private 4096x32 scratch
// memory, with environment-controlled muxes on every memory port.
module weight_az_top
   import weight_az_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
   input  logic [ADDR_W-1:0] A,
   input  logic [ADDR_W-1:0] AP,
   input  logic [ADDR_W-1:0] gammaAddr,
   input  logic [ADDR_W-1:0] wazReadRequested,
   input  logic [ADDR_W-1:0] wazWriteRequested,
   input  logic [DATA_W-1:0] wazOut,
   input  logic              wazWrite,
   input  logic              wazMuxSel,
   input  logic              wazMux1Sel,
   input  logic              wazMux2Sel,
   input  logic              wazMux3Sel,
   output logic [DATA_W-1:0] readIn
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   state_t            state;
   logic [3:0]        idx;
   logic [15:0]       gamma_q;
   logic [15:0]       fac_q;
   logic [15:0]       a_q;
   logic [15:0]       ap_q;
   logic [15:0]       ap_term;
   logic [15:0]       fac_next;

   logic [ADDR_W-1:0] fsm_rd_addr;
   logic [ADDR_W-1:0] fsm_wr_addr;
   logic [DATA_W-1:0] fsm_wr_data;
   logic              fsm_we;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              we;

   logic [DATA_W-1:0] mem [DEPTH];

   weight_az_mult_round u_ap_term (
      .x (a_q),
      .y (fac_q),
      .z (ap_term)
   );

   weight_az_mult_round u_fac_next (
      .x (gamma_q),
      .y (fac_q),
      .z (fac_next)
   );

   // FSM-side memory requests and the environment muxes
   always_comb begin
      fsm_rd_addr = (state == RD_GAMMA) ? gammaAddr : A + ADDR_W'(idx);
      fsm_wr_addr = AP + ADDR_W'(idx);
      fsm_wr_data = {16'h0000, ap_q};
      fsm_we      = (state == WR_AP);
      rd_addr     = wazMuxSel  ? fsm_rd_addr : wazReadRequested;
      wr_addr     = wazMux1Sel ? fsm_wr_addr : wazWriteRequested;
      wr_data     = wazMux2Sel ? fsm_wr_data : wazOut;
      we          = wazMux3Sel ? fsm_we      : wazWrite;
   end

   // Writes are blocked while reset is held
   always_ff @(posedge clk) begin
      if (we && reset)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         readIn <= '0;
      else
         readIn <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         done    <= 1'b0;
         idx     <= '0;
         gamma_q <= '0;
         fac_q   <= '0;
         a_q     <= '0;
         ap_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  done  <= 1'b0;
                  idx   <= '0;
                  state <= RD_GAMMA;
               end
            end
            RD_GAMMA:   state <= WAIT_GAMMA;
            WAIT_GAMMA: begin
               gamma_q <= readIn[15:0];
               fac_q   <= readIn[15:0];
               state   <= RD_A;
            end
            RD_A:       state <= WAIT_A;
            WAIT_A: begin
               a_q   <= readIn[15:0];
               state <= CALC;
            end
            CALC: begin
               if (idx == 4'd0) begin
                  ap_q <= a_q;
               end else begin
                  ap_q  <= ap_term;
                  fac_q <= fac_next;
               end
               state <= WR_AP;
            end
            WR_AP: begin
               if (idx == 4'(M)) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= RD_A;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_az_top.sv
// Bench for weight_az_top: preloads frames through the external muxes, runs
// the FSM and compares every ap word against an independent model.
module tb_weight_az_top;
   import weight_az_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        done;
   logic [11:0] A, AP, gammaAddr, wazReadRequested, wazWriteRequested;
   logic [31:0] wazOut;
   logic        wazWrite, wazMuxSel, wazMux1Sel, wazMux2Sel, wazMux3Sel;
   logic [31:0] readIn;

   weight_az_top dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .done              (done),
      .A                 (A),
      .AP                (AP),
      .gammaAddr         (gammaAddr),
      .wazReadRequested  (wazReadRequested),
      .wazWriteRequested (wazWriteRequested),
      .wazOut            (wazOut),
      .wazWrite          (wazWrite),
      .wazMuxSel         (wazMuxSel),
      .wazMux1Sel        (wazMux1Sel),
      .wazMux2Sel        (wazMux2Sel),
      .wazMux3Sel        (wazMux3Sel),
      .readIn            (readIn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] gamma;
      logic [15:0] a0;
      logic [15:0] a1;
      logic [15:0] exp_ap0;
      logic [15:0] exp_ap1;
   } vec_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          lat_ref = -1;
   logic [15:0] cur_a  [11];
   logic [31:0] rd_ap  [11];
   logic [31:0] sb_q   [$];
   vec_t        tbl    [5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference round(L_mult(x,y)) in 64-bit integer arithmetic
   function automatic logic [15:0] m_mr(input logic [15:0] x, input logic [15:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y)) * 2;
      if (p > 64'sd2147483647) p = 64'sd2147483647;
      p = p + 64'sd32768;
      if (p > 64'sd2147483647) p = 64'sd2147483647;
      return 16'(p >>> 16);
   endfunction

   task automatic wr(input logic [11:0] ad, input logic [31:0] d);
      wazMux1Sel = 0; wazMux2Sel = 0; wazMux3Sel = 0;
      wazWriteRequested = ad; wazOut = d; wazWrite = 1;
      @(posedge clk); #1;
      wazWrite = 0;
   endtask

   task automatic rd(input logic [11:0] ad, output logic [31:0] d);
      wazMuxSel = 0; wazReadRequested = ad;
      @(posedge clk); #1;
      d = readIn;
   endtask

   // Preload gamma and cur_a with junk in the upper halves; queue the model result
   task automatic load_frame(input logic [11:0] ab, input logic [11:0] gb,
                             input logic [15:0] g, input bit push);
      logic [15:0] fac;
      wr(gb, {16'hA5A5, g});
      for (int k = 0; k < 11; k++) wr(ab + 12'(k), {16'hC3C3, cur_a[k]});
      if (push) begin
         sb_q.push_back({16'h0000, cur_a[0]});
         fac = g;
         for (int k = 1; k < 11; k++) begin
            sb_q.push_back({16'h0000, m_mr(cur_a[k], fac)});
            fac = m_mr(g, fac);
         end
      end
   endtask

   task automatic run_frame(input logic [11:0] ab, input logic [11:0] apb,
                            input logic [11:0] gb, input bit busy_poke);
      int cycles;
      A = ab; AP = apb; gammaAddr = gb;
      wazMuxSel = 1; wazMux1Sel = 1; wazMux2Sel = 1; wazMux3Sel = 1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      check("done_cleared", done, 0);
      cycles = 1;
      while (done !== 1'b1 && cycles < 100) begin
         start = busy_poke && (cycles == 10);
         @(posedge clk); #1;
         cycles++;
      end
      start = 0;
      check("done_seen", done, 1);
      check("latency_le_60", 32'(cycles <= 60), 1);
      if (lat_ref < 0) lat_ref = cycles;
      else check("latency_fixed", 32'(cycles), 32'(lat_ref));
      wazMuxSel = 0; wazMux1Sel = 0; wazMux2Sel = 0; wazMux3Sel = 0;
   endtask

   task automatic drain(input logic [11:0] apb);
      logic [31:0] d;
      for (int k = 0; k < 11; k++) begin
         rd(apb + 12'(k), d);
         rd_ap[k] = d;
         if (sb_q.size() == 0) check("sb_empty", 1, 0);
         else check($sformatf("ap[%0d]", k), d, sb_q.pop_front());
      end
      check("done_held", done, 1);
   endtask

   initial begin
      logic [31:0] d;
      logic [11:0] ab, apb, gb;
      logic [15:0] g;

      tbl[0] = '{gamma: 16'h7FFF, a0: 16'h1000, a1: 16'h0800, exp_ap0: 16'h1000, exp_ap1: 16'h0800};
      tbl[1] = '{gamma: 16'h6666, a0: 16'h1000, a1: 16'hE000, exp_ap0: 16'h1000, exp_ap1: 16'hE667};
      tbl[2] = '{gamma: 16'h8000, a0: 16'h1000, a1: 16'h8000, exp_ap0: 16'h1000, exp_ap1: 16'h7FFF};
      tbl[3] = '{gamma: 16'h0000, a0: 16'h1234, a1: 16'h4000, exp_ap0: 16'h1234, exp_ap1: 16'h0000};
      tbl[4] = '{gamma: 16'h7000, a0: 16'hF000, a1: 16'h7FFF, exp_ap0: 16'hF000, exp_ap1: 16'h6FFF};

      reset = 0; start = 0; A = 0; AP = 0; gammaAddr = 0;
      wazReadRequested = 0; wazWriteRequested = 0; wazOut = 0; wazWrite = 0;
      wazMuxSel = 0; wazMux1Sel = 0; wazMux2Sel = 0; wazMux3Sel = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", done, 0);
      check("reset_readIn", readIn, 0);
      reset = 1;
      @(posedge clk); #1;

      // Read-during-write on the external port returns the old word
      wr(12'hE00, 32'h0BAD_F00D);
      wazWriteRequested = 12'hE00; wazOut = 32'h1357_9BDF; wazWrite = 1;
      wazReadRequested = 12'hE00; wazMuxSel = 0;
      @(posedge clk); #1;
      wazWrite = 0;
      check("rdw_old", readIn, 32'h0BAD_F00D);
      rd(12'hE00, d);
      check("rdw_new", d, 32'h1357_9BDF);

      // Directed table at the default system addresses
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 11; k++) begin
            if (r == 0) cur_a[k] = 16'h1000 >> k;
            else        cur_a[k] = 16'((r * 4967 + k * 3855) ^ (k << 12));
         end
         cur_a[0] = tbl[r].a0;
         cur_a[1] = tbl[r].a1;
         load_frame(A_BASE, GAMMA_ADDR, tbl[r].gamma, 1);
         run_frame(A_BASE, AP_BASE, GAMMA_ADDR, r == 2);
         drain(AP_BASE);
         check($sformatf("tbl%0d_ap0", r), rd_ap[0], {16'h0000, tbl[r].exp_ap0});
         check($sformatf("tbl%0d_ap1", r), rd_ap[1], {16'h0000, tbl[r].exp_ap1});
         if (r == 3) check("zero_gamma_ap10", rd_ap[10], 0);
      end

      // Random frames at random 16-aligned bases, back to back
      for (int f = 0; f < 15; f++) begin
         ab  = 12'(16 * $urandom_range(0, 63));
         apb = 12'(16 * $urandom_range(64, 127));
         gb  = 12'(16 * $urandom_range(128, 191));
         g   = 16'($urandom);
         if (f == 0) g = 16'h8000;
         for (int k = 0; k < 11; k++) cur_a[k] = 16'($urandom);
         if (f == 0) cur_a[1] = 16'h8000;
         load_frame(ab, gb, g, 1);
         run_frame(ab, apb, gb, f == 5);
         drain(apb);
      end

      // Reset mid-run: must go idle, drop done, block writes, then recover
      wr(12'hF00, 32'h1111_2222);
      for (int k = 0; k < 11; k++) cur_a[k] = 16'($urandom);
      load_frame(A_BASE, GAMMA_ADDR, 16'h4000, 0);
      A = A_BASE; AP = AP_BASE; gammaAddr = GAMMA_ADDR;
      wazMuxSel = 1; wazMux1Sel = 1; wazMux2Sel = 1; wazMux3Sel = 1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (20) @(posedge clk);
      #1;
      wazMux1Sel = 0; wazMux2Sel = 0; wazMux3Sel = 0;
      wazWriteRequested = 12'hF00; wazOut = 32'hDEAD_BEEF; wazWrite = 1;
      reset = 0;
      #1;
      check("midrst_done", done, 0);
      check("midrst_readIn", readIn, 0);
      repeat (2) @(posedge clk);
      #1;
      wazWrite = 0;
      reset = 1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_after_rst", done, 0);
      rd(12'hF00, d);
      check("no_write_in_reset", d, 32'h1111_2222);
      for (int k = 0; k < 11; k++) cur_a[k] = 16'($urandom);
      load_frame(A_BASE, GAMMA_ADDR, 16'h7333, 1);
      run_frame(A_BASE, AP_BASE, GAMMA_ADDR, 0);
      drain(AP_BASE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
